// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
//   Shared types and defaults for the F1 start-light reaction timer.
//
//   Contents:
//     rt_state_t      controller state encoding
//     MAX_MS_DEFAULT  saturation / timeout limit in ms (fits four BCD digits)
//     CNT_W_DEFAULT   width of the ms counter and result
//     SYNC_DEFAULT    depth of the button synchroniser
//     state_is_busy() true while a run is in progress (ARMED or TIMING)
//
//   Optional feature macro used elsewhere in this slice: REACTION_BEST_EN.
// ----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE,
        FAULT
    } rt_state_t;

    localparam int unsigned MAX_MS_DEFAULT = 9999;
    localparam int unsigned CNT_W_DEFAULT  = 14;
    localparam int unsigned SYNC_DEFAULT   = 2;

    // A run is "in progress" from start_seq until a press, fault or timeout.
    function automatic logic state_is_busy(rt_state_t s);
        return (s == ARMED) || (s == TIMING);
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// ----------------------------------------------------------------------------
// reaction_timer_if
//   Bundles the event inputs and result outputs of the reaction timer.
//   Clock and reset are kept outside the interface as plain ports.
//
//   Signals:
//     tick_ms      1-clk enable pulse every 1 ms
//     start_seq    1-clk pulse, light sequence has begun
//     lights_out   1-clk pulse, all lights extinguished
//     react_raw    driver button, active-high, asynchronous
//     reaction_ms  captured reaction time in ms
//     result_valid reaction_ms holds a valid result
//     jump_start   press seen before lights_out
//     timeout      no press within MAX_MS after lights_out
//     busy         run in progress
//     best_ms      best valid reaction since reset (REACTION_BEST_EN only)
//
//   Modports:
//     master  stimulus / display side (drives events, reads results)
//     slave   the reaction timer itself
// ----------------------------------------------------------------------------
interface reaction_timer_if
    import reaction_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);

    logic             tick_ms;
    logic             start_seq;
    logic             lights_out;
    logic             react_raw;
    logic [CNT_W-1:0] reaction_ms;
    logic             result_valid;
    logic             jump_start;
    logic             timeout;
    logic             busy;
`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0] best_ms;
`endif

    modport master (
        output tick_ms,
        output start_seq,
        output lights_out,
        output react_raw,
        input  reaction_ms,
        input  result_valid,
        input  jump_start,
        input  timeout,
`ifdef REACTION_BEST_EN
        input  best_ms,
`endif
        input  busy
    );

    modport slave (
        input  tick_ms,
        input  start_seq,
        input  lights_out,
        input  react_raw,
        output reaction_ms,
        output result_valid,
        output jump_start,
        output timeout,
`ifdef REACTION_BEST_EN
        output best_ms,
`endif
        output busy
    );

endinterface

// File: rtl/btn_sync_edge.sv
// ----------------------------------------------------------------------------
// btn_sync_edge
//   Synchronises an asynchronous push-button level into the clk domain and
//   emits a single-cycle pulse on each rising edge. A held button yields one
//   pulse only. Reusable for any KEY input.
//
//   Latency: SYNC_STAGES + 1 clk from the din edge to pulse (pulse is a flop).
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset, clears every flop
//     din    asynchronous level input
//     pulse  registered 1-clk rising-edge pulse
// ----------------------------------------------------------------------------
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// ----------------------------------------------------------------------------
// reaction_timer
//   Driver-side responder to the F1 start-light sequence. Arms on start_seq,
//   counts tick_ms pulses from lights_out until the driver presses the button
//   and reports the binary reaction time for the bin2bcd / 7-segment path.
//   A press before lights_out flags a jump start; no press within MAX_MS ms
//   flags a timeout. All outputs are registered.
//
//   Parameters:
//     MAX_MS       saturation / timeout limit in ms (2**CNT_W must exceed it)
//     CNT_W        counter and result width
//     SYNC_STAGES  button synchroniser depth, minimum 2
//
//   Ports:
//     clk    system clock (50 MHz)
//     rst_n  asynchronous active-low reset; aborts any run with no result
//     bus    reaction_timer_if.slave (events in, results out)
//
//   Optional feature (macro REACTION_BEST_EN): adds bus.best_ms, the best
//   valid reaction time since reset, initialised to MAX_MS.
// ----------------------------------------------------------------------------
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned MAX_MS      = MAX_MS_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    reaction_timer_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MS);

    rt_state_t        state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] reaction_ms_q;
    logic             result_valid_q;
    logic             jump_start_q;
    logic             timeout_q;
    logic             busy_q;
    logic             react_pulse;

    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.react_raw),
        .pulse(react_pulse)
    );

    // Single registered FSM: state, counter and every output flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            reaction_ms_q  <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else if (bus.start_seq) begin
            // Restart from any state; the last reaction time stays on display.
            state_q        <= ARMED;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= state_is_busy(ARMED);
        end else begin
            case (state_q)
                ARMED: begin
                    // A press coincident with lights_out is still a jump start.
                    if (react_pulse) begin
                        state_q      <= FAULT;
                        jump_start_q <= 1'b1;
                        busy_q       <= state_is_busy(FAULT);
                    end else if (bus.lights_out) begin
                        state_q <= TIMING;
                        count_q <= '0;
                    end
                end
                TIMING: begin
                    if (react_pulse) begin
                        // Capture the pre-increment count: a press landing on the
                        // tick that would reach MAX_MS reports MAX_MS-1.
                        state_q        <= DONE;
                        reaction_ms_q  <= count_q;
                        result_valid_q <= 1'b1;
                        busy_q         <= state_is_busy(DONE);
                    end else if (bus.tick_ms) begin
                        if (count_q >= MAX_CNT - 1'b1) begin
                            // Saturate and give up waiting for the driver.
                            state_q        <= DONE;
                            count_q        <= MAX_CNT;
                            reaction_ms_q  <= MAX_CNT;
                            result_valid_q <= 1'b0;
                            timeout_q      <= 1'b1;
                            busy_q         <= state_is_busy(DONE);
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                IDLE, DONE, FAULT: begin
                    // Presses, ticks and lights_out are ignored; outputs hold.
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reaction_ms  = reaction_ms_q;
    assign bus.result_valid = result_valid_q;
    assign bus.jump_start   = jump_start_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;

`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0] best_q;
    logic             valid_d1_q;

    // result_valid only rises on a genuine press capture, so its rising edge
    // marks exactly the results eligible for the best-time record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= MAX_CNT;
            valid_d1_q <= 1'b0;
        end else begin
            valid_d1_q <= result_valid_q;
            if (result_valid_q && !valid_d1_q && (reaction_ms_q < best_q)) begin
                best_q <= reaction_ms_q;
            end
        end
    end

    assign bus.best_ms = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// ----------------------------------------------------------------------------
// tb_reaction_timer
//   Directed bench for reaction_timer. A timestamp-style model follows the
//   run rules (armed / timing / finished, ticks seen since lights_out, press
//   arrival delayed by the synchroniser) and is compared against the DUT on
//   every falling edge; literal checks pin the model at key points.
// ----------------------------------------------------------------------------
module tb_reaction_timer;
    import reaction_pkg::*;

    localparam int MAX_MS = 9999;
    localparam int CNT_W  = 14;
    localparam int SYNC   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reaction_timer_if #(.CNT_W(CNT_W)) bus ();

    reaction_timer #(
        .MAX_MS     (MAX_MS),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // phase: 0 idle, 1 waiting for lights, 2 counting, 3 finished
    int               m_phase = 0;
    int               m_ticks = 0;
    int               m_rms   = 0;
    bit               m_valid = 0;
    bit               m_jump  = 0;
    bit               m_to    = 0;
    int               m_best  = MAX_MS;
    bit               m_pend  = 0;
    logic [SYNC+1:0]  hist    = '0;  // hist[i] = react_raw seen i+1 edges ago

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_ticks = 0; m_rms = 0; m_valid = 0; m_jump = 0;
            m_to = 0; m_best = MAX_MS; m_pend = 0; hist = '0;
        end else begin
            bit press;
            // Button reaches the controller SYNC+2 edges after it is sampled.
            press = hist[SYNC] && !hist[SYNC+1];
            if (m_pend && m_rms < m_best) m_best = m_rms;
            m_pend = 0;
            if (bus.start_seq) begin
                m_phase = 1; m_ticks = 0; m_valid = 0; m_jump = 0; m_to = 0;
            end else if (m_phase == 1) begin
                if (press) begin
                    m_phase = 3; m_jump = 1;
                end else if (bus.lights_out) begin
                    m_phase = 2; m_ticks = 0;
                end
            end else if (m_phase == 2) begin
                if (press) begin
                    m_phase = 3; m_rms = m_ticks; m_valid = 1; m_pend = 1;
                end else if (bus.tick_ms) begin
                    m_ticks++;
                    if (m_ticks == MAX_MS) begin
                        m_phase = 3; m_to = 1; m_rms = MAX_MS;
                    end
                end
            end
            hist = {hist[SYNC:0], bus.react_raw};
        end
    end

    always @(negedge clk) begin
        chk("reaction_ms", 32'(bus.reaction_ms), 32'(m_rms));
        chk("result_valid", 32'(bus.result_valid), 32'(m_valid));
        chk("jump_start", 32'(bus.jump_start), 32'(m_jump));
        chk("timeout", 32'(bus.timeout), 32'(m_to));
        chk("busy", 32'(bus.busy), 32'(m_phase == 1 || m_phase == 2));
`ifdef REACTION_BEST_EN
        chk("best_ms", 32'(bus.best_ms), 32'(m_best));
`endif
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse();
        bus.start_seq = 1'b1;
        @(negedge clk);
        bus.start_seq = 1'b0;
    endtask

    task automatic lights_pulse();
        bus.lights_out = 1'b1;
        @(negedge clk);
        bus.lights_out = 1'b0;
    endtask

    task automatic ticks(input int n);
        if (n > 0) begin
            bus.tick_ms = 1'b1;
            repeat (n) @(negedge clk);
            bus.tick_ms = 1'b0;
        end
    endtask

    task automatic press();
        bus.react_raw = 1'b1;
        idle(6);
        bus.react_raw = 1'b0;
        idle(3);
    endtask

    // Press whose synchronised pulse lands on the same edge as a tick.
    task automatic press_with_tick();
        bus.react_raw = 1'b1;
        idle(3);
        bus.tick_ms = 1'b1;
        @(negedge clk);
        bus.tick_ms = 1'b0;
        idle(3);
        bus.react_raw = 1'b0;
        idle(3);
    endtask

    task automatic run(input int n);
        start_pulse();
        lights_pulse();
        ticks(n);
        press();
    endtask

    initial begin
        bus.tick_ms = 1'b0; bus.start_seq = 1'b0; bus.lights_out = 1'b0;
        bus.react_raw = 1'b0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("rst reaction_ms", 32'(bus.reaction_ms), 0);
        chk("rst result_valid", 32'(bus.result_valid), 0);
        chk("rst busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        idle(2);

        // Press and lights_out ignored in IDLE.
        lights_pulse();
        press();
        chk("idle ignore busy", 32'(bus.busy), 0);

        // Normal run.
        start_pulse();
        chk("armed busy", 32'(bus.busy), 1);
        lights_pulse();
        ticks(187);
        press();
        chk("normal reaction_ms", 32'(bus.reaction_ms), 187);
        chk("normal result_valid", 32'(bus.result_valid), 1);
        chk("normal busy", 32'(bus.busy), 0);
        chk("normal jump_start", 32'(bus.jump_start), 0);

        // Jump start, then a late lights_out changes nothing.
        start_pulse();
        ticks(3);
        press();
        chk("jump jump_start", 32'(bus.jump_start), 1);
        chk("jump busy", 32'(bus.busy), 0);
        lights_pulse();
        idle(2);
        chk("jump reaction_ms kept", 32'(bus.reaction_ms), 187);
        chk("jump result_valid", 32'(bus.result_valid), 0);

        // Press coincident with lights_out.
        start_pulse();
        idle(2);
        bus.react_raw = 1'b1;
        idle(3);
        bus.lights_out = 1'b1;
        @(negedge clk);
        bus.lights_out = 1'b0;
        idle(3);
        bus.react_raw = 1'b0;
        idle(3);
        chk("coinc lights jump_start", 32'(bus.jump_start), 1);

        // Press coincident with a tick at count 42.
        start_pulse();
        lights_pulse();
        ticks(42);
        press_with_tick();
        chk("coinc tick reaction_ms", 32'(bus.reaction_ms), 42);
        chk("coinc tick result_valid", 32'(bus.result_valid), 1);

        // Press on the tick that would reach MAX_MS: valid MAX_MS-1.
        start_pulse();
        lights_pulse();
        ticks(MAX_MS - 1);
        press_with_tick();
        chk("edge reaction_ms", 32'(bus.reaction_ms), 32'(MAX_MS - 1));
        chk("edge result_valid", 32'(bus.result_valid), 1);
        chk("edge timeout", 32'(bus.timeout), 0);

        // Timeout, extra ticks and a late press change nothing.
        start_pulse();
        lights_pulse();
        ticks(MAX_MS);
        idle(2);
        chk("to timeout", 32'(bus.timeout), 1);
        chk("to reaction_ms", 32'(bus.reaction_ms), 32'(MAX_MS));
        chk("to result_valid", 32'(bus.result_valid), 0);
        chk("to busy", 32'(bus.busy), 0);
        ticks(5);
        press();
        chk("to hold reaction_ms", 32'(bus.reaction_ms), 32'(MAX_MS));
        chk("to hold result_valid", 32'(bus.result_valid), 0);

        // Restart during TIMING at count 500.
        start_pulse();
        lights_pulse();
        ticks(500);
        start_pulse();
        chk("restart busy", 32'(bus.busy), 1);
        chk("restart timeout", 32'(bus.timeout), 0);
        chk("restart reaction_ms kept", 32'(bus.reaction_ms), 32'(MAX_MS));
        lights_pulse();
        ticks(10);
        press();
        chk("restart reaction_ms", 32'(bus.reaction_ms), 10);

        // Asynchronous reset mid-TIMING.
        start_pulse();
        lights_pulse();
        ticks(20);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst reaction_ms", 32'(bus.reaction_ms), 0);
        chk("async rst busy", 32'(bus.busy), 0);
        chk("async rst result_valid", 32'(bus.result_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

`ifdef REACTION_BEST_EN
        chk("best reset", 32'(bus.best_ms), 32'(MAX_MS));
        run(250); idle(2);
        chk("best after 250", 32'(bus.best_ms), 250);
        run(180); idle(2);
        chk("best after 180", 32'(bus.best_ms), 180);
        start_pulse(); ticks(3); press(); idle(2);
        chk("best after jump", 32'(bus.best_ms), 180);
        run(300); idle(2);
        chk("best after 300", 32'(bus.best_ms), 180);
`else
        run(77);
        chk("final reaction_ms", 32'(bus.reaction_ms), 77);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Driver-side responder to the F1 start-light sequence.
- Arms when the light sequence starts and counts milliseconds from lights-out to the driver's button press.
- Reports a binary reaction time for the bin2bcd / 7-segment path.
- Flags a jump start if the button is pressed before lights-out, and a timeout if the driver never responds.

Parameters:
- MAX_MS, 9999: saturation and timeout limit in ms, chosen to fit four BCD digits.
- CNT_W, 14: width of the ms counter and result; must satisfy 2**CNT_W > MAX_MS.
- SYNC_STAGES, 2: flop depth of the button synchroniser, minimum 2.

Ports:
- clk  input  1  system clock, 50 MHz (MAX10_CLK1_50 at top level).
- rst_n  input  1  asynchronous active-low reset.
- tick_ms  input  1  one-clk-wide enable pulse every 1 ms (from clktick).
- start_seq  input  1  one-clk pulse: light sequence has begun.
- lights_out  input  1  one-clk pulse: all lights extinguished (race start).
- react_raw  input  1  driver button, active-high (top inverts KEY), asynchronous.
- reaction_ms  output  CNT_W  captured reaction time in ms.
- result_valid  output  1  level: reaction_ms holds a valid result.
- jump_start  output  1  level: press detected before lights_out.
- timeout  output  1  level: no press within MAX_MS after lights_out.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count, reaction_ms, result_valid, jump_start, timeout, busy all 0; synchroniser flops cleared.
  - Reset mid-operation aborts immediately with no result.
- Button path:
  - react_raw passes through SYNC_STAGES flops, then a rising-edge detect producing react_pulse.
  - Latency is SYNC_STAGES+1 clk from the react_raw edge.
  - A held button produces one pulse only.
- IDLE:
  - react_pulse and lights_out are ignored.
  - start_seq -> ARMED, next clk: clear result_valid, jump_start, timeout and count.
- ARMED (busy=1):
  - react_pulse -> FAULT; jump_start=1.
  - lights_out -> TIMING; count=0.
  - react_pulse and lights_out in the same cycle -> FAULT (the press wins).
- TIMING (busy=1):
  - Each tick_ms increments count.
  - react_pulse -> DONE; reaction_ms <= count as it was before that cycle's increment; result_valid=1.
  - If count reaches MAX_MS on a tick -> DONE; timeout=1; reaction_ms=MAX_MS; result_valid=0.
  - react_pulse on the same cycle the count reaches MAX_MS -> capture MAX_MS-1 and treat as a valid press, not a timeout.
- DONE / FAULT:
  - busy=0; outputs hold; react_pulse and lights_out are ignored.
- start_seq in any state, including TIMING, restarts into ARMED with flags cleared and reaction_ms kept.
- start_seq has priority over every other event in the same cycle.
- Counter never wraps: it saturates at MAX_MS.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: REACTION_BEST_EN.
- When defined:
  - Adds output best_ms [CNT_W-1:0], reset to MAX_MS.
  - On each valid DONE capture, if reaction_ms < best_ms, then best_ms <= reaction_ms on the following clk.
  - best_ms is not updated on FAULT or timeout, and is cleared only by rst_n.
- When undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package reaction_pkg holds:
  - typedef enum logic [2:0] rt_state_t {IDLE, ARMED, TIMING, DONE, FAULT};
  - localparam defaults for MAX_MS and CNT_W.
- Sub-module btn_sync_edge (parameter SYNC_STAGES):
  - ports clk, rst_n, din, pulse.
  - Reusable for other KEY inputs.
- Counter and FSM stay in reaction_timer.

Test Plan:
- Normal run: start_seq; lights_out; after 187 tick_ms pulses raise react_raw -> reaction_ms=187, result_valid=1, busy=0, jump_start=0.
- Jump start: start_seq; react_raw high 3 ticks later, before lights_out -> jump_start=1, state FAULT; later lights_out leaves reaction_ms unchanged and result_valid=0.
- Timeout: start_seq; lights_out; no press for 9999 ticks -> timeout=1, reaction_ms=9999, result_valid=0; extra ticks do not change count.
- Simultaneous events:
  - react_pulse coincident with lights_out -> jump_start=1.
  - react_pulse coincident with tick_ms at count=42 -> reaction_ms=42.
- Restart and reset: start_seq during TIMING at count=500 -> ARMED, flags cleared, count=0; rst_n low mid-TIMING -> all outputs 0 asynchronously, IDLE.
- REACTION_BEST_EN: runs of 250, 180, jump start, 300 -> best_ms 250, then 180, then 180, then 180.
